// File: rtl/vga_timing_ctrl_if.sv
// Raster timing bundle between the VGA timing controller and its consumers.
// The controller takes the run enable and drives the sync, video and strobe signals.
interface vga_timing_ctrl_if;
  logic       en;
  logic       pix_tick;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] x;
  logic [9:0] y;
  logic       line_start;
  logic       frame_start;

  modport master (
    input  en,
    output pix_tick, hsync, vsync, video_on, x, y, line_start, frame_start
  );

  modport slave (
    output en,
    input  pix_tick, hsync, vsync, video_on, x, y, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: divide-by-DIV pixel enable, horizontal/vertical porch-sync
// state machines, and registered sync, video, coordinate and strobe outputs.
module vga_timing_ctrl #(
  parameter int DIV      = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_ctrl_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(DIV);

  if (DIV < 2 || H_TOTAL > 1024 || V_TOTAL > 1024 ||
      H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
    $error("vga_timing_ctrl: illegal timing parameters");
  end

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_FRONT  = 2'd1;
  localparam logic [1:0] ST_SYNC   = 2'd2;
  localparam logic [1:0] ST_BACK   = 2'd3;

  // Last count value of each region; the axis FSM leaves a region on these.
  localparam logic [9:0] H_END_ACT  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_END_FP   = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_END_SYNC = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_END      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_END_ACT  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_END_FP   = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_END_SYNC = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_END      = 10'(V_TOTAL - 1);

  function automatic logic [1:0] axis_next(input logic [1:0] st, input logic [9:0] cnt,
                                           input logic [9:0] end_act, input logic [9:0] end_fp,
                                           input logic [9:0] end_sync, input logic [9:0] end_all);
    axis_next = st;
    case (st)
      ST_ACTIVE: if (cnt == end_act)  axis_next = ST_FRONT;
      ST_FRONT:  if (cnt == end_fp)   axis_next = ST_SYNC;
      ST_SYNC:   if (cnt == end_sync) axis_next = ST_BACK;
      default:   if (cnt == end_all)  axis_next = ST_ACTIVE;
    endcase
  endfunction

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [1:0]       h_st_q, h_st_d, v_st_q, v_st_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic             tick, h_wrap, v_wrap;

  assign tick   = vga.en && (div_cnt_q == DIV_W'(DIV - 1));
  assign h_wrap = (h_cnt_q == H_END);
  assign v_wrap = (v_cnt_q == V_END);

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    div_cnt_d = div_cnt_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    h_st_d    = h_st_q;
    v_st_d    = v_st_q;

    if (vga.en) div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);

    if (tick) begin
      h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
      h_st_d  = axis_next(h_st_q, h_cnt_q, H_END_ACT, H_END_FP, H_END_SYNC, H_END);
      if (h_wrap) begin
        v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
        v_st_d  = axis_next(v_st_q, v_cnt_q, V_END_ACT, V_END_FP, V_END_SYNC, V_END);
      end
    end

    // Outputs follow the next-state values so they change on the same edge as the counters.
    video_on_d    = vga.en && (h_st_d == ST_ACTIVE) && (v_st_d == ST_ACTIVE);
    x_d           = video_on_d ? h_cnt_d : 10'd0;
    y_d           = video_on_d ? v_cnt_d : 10'd0;
    hsync_d       = (h_st_d == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (v_st_d == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
    line_start_d  = tick && h_wrap;
    frame_start_d = tick && h_wrap && v_wrap;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      h_st_q        <= ST_ACTIVE;
      v_st_q        <= ST_ACTIVE;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_st_q        <= h_st_d;
      v_st_q        <= v_st_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.pix_tick    = tick;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: a default 640x480 build checks line timing and enable gating; a tiny
// DIV=2 active-high build (15x11 raster, 330 clks/frame) checks frame timing and async reset.
module tb_vga_timing_ctrl;
  logic clk;
  logic rst_n;

  vga_timing_ctrl_if vga_a ();
  vga_timing_ctrl_if vga_b ();

  vga_timing_ctrl u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vga_a)
  );

  vga_timing_ctrl #(
    .DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vga_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int a_hs_low, a_vid, a_ls, a_fs, a_first_hs;
  int b_vs_hi, b_hs_hi, b_vid, b_ls, b_fs, b_first_vs, b_last_fs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0;
    a_hs_low = 0; a_vid = 0; a_ls = 0; a_fs = 0; a_first_hs = -1;
    b_vs_hi = 0; b_hs_hi = 0; b_vid = 0; b_ls = 0; b_fs = 0; b_first_vs = -1; b_last_fs = -1;
  endtask

  // One clock: sample on the falling edge and accumulate per-cycle statistics.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (!vga_a.hsync) begin a_hs_low++; if (a_first_hs < 0) a_first_hs = cyc; end
    if (vga_a.video_on)    a_vid++;
    if (vga_a.line_start)  a_ls++;
    if (vga_a.frame_start) a_fs++;
    if (vga_b.vsync) begin b_vs_hi++; if (b_first_vs < 0) b_first_vs = cyc; end
    if (vga_b.hsync)       b_hs_hi++;
    if (vga_b.video_on)    b_vid++;
    if (vga_b.line_start)  b_ls++;
    if (vga_b.frame_start) begin b_fs++; b_last_fs = cyc; end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    vga_a.en = 1'b1;
    vga_b.en = 1'b1;
    clear_stats();
    @(negedge clk);
    @(negedge clk);

    check("rst_a_pix_tick", vga_a.pix_tick, 0);
    check("rst_a_hsync", vga_a.hsync, 1);
    check("rst_a_vsync", vga_a.vsync, 1);
    check("rst_a_video_on", vga_a.video_on, 0);
    check("rst_a_x", vga_a.x, 0);
    check("rst_a_y", vga_a.y, 0);
    check("rst_a_line_start", vga_a.line_start, 0);
    check("rst_a_frame_start", vga_a.frame_start, 0);
    check("rst_b_hsync", vga_b.hsync, 0);
    check("rst_b_vsync", vga_b.vsync, 0);

    rst_n = 1'b1;
    clear_stats();

    // Divider start-up: tick every 4th clk for A, every 2nd for B; x steps once per tick.
    for (int k = 1; k <= 8; k++) begin
      step();
      check("a_pix_tick_startup", vga_a.pix_tick, ((k % 4) == 3) ? 1 : 0);
      check("a_x_startup", vga_a.x, k / 4);
      check("b_pix_tick_startup", vga_b.pix_tick, ((k % 2) == 1) ? 1 : 0);
      if (k == 1) check("a_video_on_first_edge", vga_a.video_on, 1);
    end

    run_to(2559);
    check("a_last_visible_x", vga_a.x, 639);
    check("a_last_visible_video_on", vga_a.video_on, 1);
    run_to(2560);
    check("a_front_video_on", vga_a.video_on, 0);
    check("a_front_x", vga_a.x, 0);
    run_to(2623);
    check("a_hsync_before_656", vga_a.hsync, 1);
    run_to(2624);
    check("a_hsync_at_656", vga_a.hsync, 0);
    run_to(3007);
    check("a_hsync_at_751", vga_a.hsync, 0);
    run_to(3008);
    check("a_hsync_at_752", vga_a.hsync, 1);
    run_to(3199);
    check("a_hsync_low_clks", a_hs_low, 384);
    check("a_hsync_first_low_clk", a_first_hs, 2624);
    check("a_video_on_clks", a_vid, 2559);
    check("a_line_start_early", a_ls, 0);
    check("a_frame_start_early", a_fs, 0);
    run_to(3200);
    check("a_line_start_pulse", vga_a.line_start, 1);
    check("a_line1_x", vga_a.x, 0);
    check("a_line1_y", vga_a.y, 1);
    check("a_line1_video_on", vga_a.video_on, 1);
    run_to(3201);
    check("a_line_start_single", vga_a.line_start, 0);

    // Enable gating at h=300 of line 1, on a clk where pix_tick is high.
    run_to(4403);
    check("a_pre_hold_x", vga_a.x, 300);
    check("a_pre_hold_pix_tick", vga_a.pix_tick, 1);
    vga_a.en = 1'b0;
    #1;
    check("a_hold_pix_tick_comb", vga_a.pix_tick, 0);
    run_to(4404);
    check("a_hold_video_on", vga_a.video_on, 0);
    check("a_hold_x", vga_a.x, 0);
    check("a_hold_y", vga_a.y, 0);
    check("a_hold_hsync", vga_a.hsync, 1);
    check("a_hold_vsync", vga_a.vsync, 1);
    run_to(4453);
    check("a_hold_end_pix_tick", vga_a.pix_tick, 0);
    check("a_hold_end_video_on", vga_a.video_on, 0);
    vga_a.en = 1'b1;
    run_to(4454);
    check("a_resume_x", vga_a.x, 301);
    check("a_resume_video_on", vga_a.video_on, 1);
    run_to(4457);
    check("a_resume_x_hold", vga_a.x, 301);
    check("a_resume_pix_tick", vga_a.pix_tick, 1);
    run_to(4458);
    check("a_resume_x_next", vga_a.x, 302);

    // Async reset with A in hsync and B at v=7,h=11 (both syncs asserted).
    run_to(6172);
    check("pre_rst_a_hsync", vga_a.hsync, 0);
    check("pre_rst_b_hsync", vga_b.hsync, 1);
    check("pre_rst_b_vsync", vga_b.vsync, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_a_hsync", vga_a.hsync, 1);
    check("async_rst_a_vsync", vga_a.vsync, 1);
    check("async_rst_a_pix_tick", vga_a.pix_tick, 0);
    check("async_rst_b_hsync", vga_b.hsync, 0);
    check("async_rst_b_vsync", vga_b.vsync, 0);
    check("async_rst_b_x", vga_b.x, 0);
    check("async_rst_b_y", vga_b.y, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();

    step();
    check("restart_a_x", vga_a.x, 0);
    check("restart_a_y", vga_a.y, 0);
    check("restart_a_video_on", vga_a.video_on, 1);
    check("restart_b_video_on", vga_b.video_on, 1);
    check("restart_b_hsync", vga_b.hsync, 0);
    run_to(4);
    check("restart_a_x_tick", vga_a.x, 1);
    check("restart_b_x_tick", vga_b.x, 2);

    // Small build frame: last visible pixel, vsync window, strobe counts, frame period.
    run_to(165);
    check("b_last_visible_x", vga_b.x, 7);
    check("b_last_visible_y", vga_b.y, 5);
    run_to(166);
    check("b_after_visible_video_on", vga_b.video_on, 0);
    check("b_after_visible_y", vga_b.y, 0);
    run_to(209);
    check("b_vsync_before_7", vga_b.vsync, 0);
    run_to(210);
    check("b_vsync_at_7", vga_b.vsync, 1);
    run_to(330);
    check("b_frame_start_pulse", vga_b.frame_start, 1);
    check("b_frame_start_count", b_fs, 1);
    check("b_line_start_count", b_ls, 11);
    check("b_vsync_high_clks", b_vs_hi, 60);
    check("b_vsync_first_clk", b_first_vs, 210);
    check("b_hsync_high_clks", b_hs_hi, 66);
    check("b_video_on_clks", b_vid, 96);
    run_to(331);
    check("b_frame_start_single", vga_b.frame_start, 0);
    run_to(660);
    check("b_frame_count_2", b_fs, 2);
    check("b_second_frame_clk", b_last_fs, 660);
    check("b_frame2_video_on", vga_b.video_on, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Sequences the VGA raster from the 100 MHz system clock using a pixel-rate clock enable in place of a derived clock.
- Generates the pixel tick internally (divide-by-DIV), runs horizontal and vertical porch/sync state machines, and drives hsync, vsync, video_on, pixel coordinates and line/frame strobes.
- Feeds the pixel generator and the top-level VGA pins.

Parameters:
- DIV, 4, system clocks per pixel; must be ≥2.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; low freezes the raster.
- pix_tick  out  1  one-clk pixel enable.
- hsync  out  1  horizontal sync at SYNC_POL when asserted.
- vsync  out  1  vertical sync at SYNC_POL when asserted.
- video_on  out  1  high during the visible region.
- x  out  10  pixel column; 0 outside the active region.
- y  out  10  pixel row; 0 outside the active region.
- line_start  out  1  one-clk pulse when h wraps to 0.
- frame_start  out  1  one-clk pulse when h and v both wrap to 0.

Behaviour:
- Interface rule: one clock (clk); asynchronous active-low reset (rst_n).
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Both must be ≤1024; checked at elaboration.
- Reset (rst_n=0, takes effect immediately without a clock):
  - div_cnt=0, h_cnt=0, v_cnt=0, both axis FSMs in ACTIVE.
  - pix_tick=0, video_on=0, x=0, y=0, line_start=0, frame_start=0.
  - hsync=vsync=~SYNC_POL.
- Divider: when en=1, div_cnt counts 0..DIV-1 and wraps. pix_tick = en & (div_cnt==DIV-1). When en=0, div_cnt holds and pix_tick=0.
  - First pix_tick falls in the DIV-th clock after reset release with en=1.
- Counters and FSMs change only on a clk edge where pix_tick=1.
- h axis FSM: ACTIVE → FRONT → SYNC → BACK → ACTIVE.
  - Transition occurs when h_cnt leaves the last position of the current region.
  - h_cnt: 0..H_TOTAL-1, wraps to 0.
  - Regions: ACTIVE = 0..639, FRONT = 640..655, SYNC = 656..751, BACK = 752..799.
- v axis FSM: same four states over v_cnt 0..V_TOTAL-1.
  - v_cnt advances only on the tick where h_cnt wraps.
  - Regions: ACTIVE = 0..479, FRONT = 480..489, SYNC = 490..491, BACK = 492..524.
  - v_cnt wraps to 0 when h and v both wrap.
- Outputs are registered and update on the same edge as the counters (zero added latency):
  - hsync = SYNC_POL iff h FSM is SYNC; vsync = SYNC_POL iff v FSM is SYNC.
  - video_on = en & hACTIVE & vACTIVE.
  - x = h_cnt if video_on, else 0; y = v_cnt if video_on, else 0.
- line_start: high for exactly the one clk following the edge where h_cnt becomes 0. frame_start: same, when (h,v) becomes (0,0).
  - Neither pulses at reset release; the first frame_start comes after one full frame.
- en deasserted mid-line: counters, FSMs, hsync and vsync hold their values; video_on forced 0; x=y=0; no strobes.
  - On re-enable, the raster resumes from the held position; div_cnt also resumes from its held value.
- Reset mid-frame: immediate return to reset values; the raster restarts at (0,0).
- Frame length: H_TOTAL*V_TOTAL*DIV clks = 1,680,000 with defaults.

Test Plan:
- Reset release with en=1 → pix_tick first high in clk 4 after release, then every 4 clks; x steps 0,1,2… once per tick; video_on=1 from the first edge.
- One full line → hsync low for exactly 96 ticks, with the falling edge on the edge where h_cnt becomes 656; line_start pulses once after 800 ticks (3200 clks); video_on high for 640 ticks.
- One full frame → vsync low for 2 lines (1600 ticks) starting at v_cnt=490; frame_start period = 1,680,000 clks; y at the last visible pixel = 479, x = 639.
- en dropped at h_cnt=300 for 50 clks → pix_tick=0, video_on=0, x=0, hsync/vsync unchanged; after re-enable, h_cnt continues at 300 with no skipped or repeated position.
- rst_n pulsed low asynchronously mid-SYNC (v_cnt=490) → vsync and hsync go high without waiting for a clock edge, and all counters read 0; normal timing resumes from (0,0).
- SYNC_POL=1, DIV=2 build → syncs are active-high; pix_tick occurs every 2 clks; frame period = 840,000 clks.
